// File: rtl/sdp_mrdma_rsp_arb_if.sv
// Response-path bundle for sdp_mrdma_rsp_arb.
// Carries the MCIF and CVIF read-response streams and the merged output stream.
interface sdp_mrdma_rsp_arb_if #(
    parameter int DW = 514
);
    logic          mcif2sdp_rd_rsp_valid;
    logic          mcif2sdp_rd_rsp_ready;
    logic [DW-1:0] mcif2sdp_rd_rsp_pd;
    logic          cvif2sdp_rd_rsp_valid;
    logic          cvif2sdp_rd_rsp_ready;
    logic [DW-1:0] cvif2sdp_rd_rsp_pd;
    logic          rsp_out_valid;
    logic          rsp_out_ready;
    logic [DW-1:0] rsp_out_pd;
    logic          rsp_out_src;

    modport slave (
        input  mcif2sdp_rd_rsp_valid,
        input  mcif2sdp_rd_rsp_pd,
        output mcif2sdp_rd_rsp_ready,
        input  cvif2sdp_rd_rsp_valid,
        input  cvif2sdp_rd_rsp_pd,
        output cvif2sdp_rd_rsp_ready,
        output rsp_out_valid,
        output rsp_out_pd,
        output rsp_out_src,
        input  rsp_out_ready
    );

    modport master (
        output mcif2sdp_rd_rsp_valid,
        output mcif2sdp_rd_rsp_pd,
        input  mcif2sdp_rd_rsp_ready,
        output cvif2sdp_rd_rsp_valid,
        output cvif2sdp_rd_rsp_pd,
        input  cvif2sdp_rd_rsp_ready,
        input  rsp_out_valid,
        input  rsp_out_pd,
        input  rsp_out_src,
        output rsp_out_ready
    );
endinterface

// File: rtl/sdp_mrdma_rsp_arb.sv
// SDP MRDMA response arbiter: round-robin MCIF/CVIF merge with beat accounting.
// Optional perf counters enabled by defining SDP_MRDMA_RSP_ARB_PERF_EN.
module sdp_mrdma_rsp_arb #(
    parameter int DW   = 514,
    parameter int CNTW = 15
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rst,
    input  logic            op_load,
    input  logic [CNTW-1:0] cfg_beat_num,
    sdp_mrdma_rsp_arb_if.slave rsp,
    output logic            sdp2mcif_rd_cdt_lat_fifo_pop,
    output logic            sdp2cvif_rd_cdt_lat_fifo_pop,
    output logic            eg_done
`ifdef SDP_MRDMA_RSP_ARB_PERF_EN
    ,
    output logic [31:0]     dp2reg_mrdma_mcif_beats,
    output logic [31:0]     dp2reg_mrdma_cvif_beats,
    output logic [31:0]     dp2reg_mrdma_out_stall
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNTW:0] ONE = (CNTW+1)'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNTW:0]   r_in_left;
    logic [CNTW:0]   r_out_left;
    logic            r_last_grant;
    logic            r_out_valid;
    logic            r_out_src;
    logic [DW-1:0]   r_out_pd;
    logic            r_pop_m;
    logic            r_pop_c;
    logic            w_grant;
    logic            w_slot_free;
    logic            w_adm_ok;
    logic            w_m_hs;
    logic            w_c_hs;
    logic            w_in_hs;
    logic            w_out_hs;
    logic            w_load;

    assign w_load      = (r_state == IDLE) && op_load;
    assign w_slot_free = !r_out_valid || rsp.rsp_out_ready;
    assign w_adm_ok    = (r_state == RUN) && (r_in_left != '0)
                         && w_slot_free;
    assign w_out_hs    = r_out_valid && rsp.rsp_out_ready;

    assign rsp.mcif2sdp_rd_rsp_ready = w_adm_ok && !w_grant;
    assign rsp.cvif2sdp_rd_rsp_ready = w_adm_ok && w_grant;

    assign w_m_hs  = rsp.mcif2sdp_rd_rsp_valid
                     && rsp.mcif2sdp_rd_rsp_ready;
    assign w_c_hs  = rsp.cvif2sdp_rd_rsp_valid
                     && rsp.cvif2sdp_rd_rsp_ready;
    assign w_in_hs = w_m_hs || w_c_hs;

    assign rsp.rsp_out_valid = r_out_valid;
    assign rsp.rsp_out_pd    = r_out_pd;
    assign rsp.rsp_out_src   = r_out_src;

    assign sdp2mcif_rd_cdt_lat_fifo_pop = r_pop_m;
    assign sdp2cvif_rd_cdt_lat_fifo_pop = r_pop_c;
    assign eg_done = (r_state == DONE);

    // Grant: lone requester wins, ties go to the source not served last.
    always_comb begin
        w_grant = !r_last_grant;
        if (rsp.mcif2sdp_rd_rsp_valid && !rsp.cvif2sdp_rd_rsp_valid)
            w_grant = 1'b0;
        else if (!rsp.mcif2sdp_rd_rsp_valid && rsp.cvif2sdp_rd_rsp_valid)
            w_grant = 1'b1;
    end

    // Layer sequencing next state.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (op_load) w_state_nxt = RUN;
            RUN:  if (w_out_hs && r_out_left == ONE) w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) r_state <= IDLE;
        else                r_state <= w_state_nxt;
    end

    // Beats still to admit and still to emit for the current layer.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_in_left  <= '0;
            r_out_left <= '0;
        end else if (w_load) begin
            r_in_left  <= {1'b0, cfg_beat_num} + ONE;
            r_out_left <= {1'b0, cfg_beat_num} + ONE;
        end else begin
            if (w_in_hs)
                r_in_left <= r_in_left - ONE;
            if (w_out_hs && r_out_left != '0)
                r_out_left <= r_out_left - ONE;
        end
    end

    // Round-robin history, moved only by an admitted beat.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) r_last_grant <= 1'b1;
        else if (w_in_hs)   r_last_grant <= w_grant;
    end

    // Output register; a reset drops any beat held here.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_out_valid <= 1'b0;
            r_out_src   <= 1'b0;
            r_out_pd    <= '0;
        end else if (w_in_hs) begin
            r_out_valid <= 1'b1;
            r_out_src   <= w_grant;
            r_out_pd    <= w_grant ? rsp.cvif2sdp_rd_rsp_pd
                                   : rsp.mcif2sdp_rd_rsp_pd;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    // One credit pop per admitted beat, to the owning interface.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_pop_m <= 1'b0;
            r_pop_c <= 1'b0;
        end else begin
            r_pop_m <= w_m_hs;
            r_pop_c <= w_c_hs;
        end
    end

`ifdef SDP_MRDMA_RSP_ARB_PERF_EN
    logic [31:0] r_mcif_beats;
    logic [31:0] r_cvif_beats;
    logic [31:0] r_out_stall;

    assign dp2reg_mrdma_mcif_beats = r_mcif_beats;
    assign dp2reg_mrdma_cvif_beats = r_cvif_beats;
    assign dp2reg_mrdma_out_stall  = r_out_stall;

    // Saturating per-layer perf counters.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst || w_load) begin
            r_mcif_beats <= '0;
            r_cvif_beats <= '0;
            r_out_stall  <= '0;
        end else begin
            if (w_m_hs && r_mcif_beats != '1)
                r_mcif_beats <= r_mcif_beats + 32'd1;
            if (w_c_hs && r_cvif_beats != '1)
                r_cvif_beats <= r_cvif_beats + 32'd1;
            if (r_out_valid && !rsp.rsp_out_ready
                && r_out_stall != '1)
                r_out_stall <= r_out_stall + 32'd1;
        end
    end
`endif

endmodule
